// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: issue/scoreboard port, ALU and LSU result handshakes,
// and the registered register-file write port.
interface wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                       issue_valid;
  logic [ADDR_WIDTH-1:0]      issue_rd;
  logic                       issue_stall;

  logic                       alu_valid;
  logic                       alu_ready;
  logic [ADDR_WIDTH-1:0]      alu_rd;
  logic [DATA_WIDTH-1:0]      alu_data;

  logic                       lsu_valid;
  logic                       lsu_ready;
  logic [ADDR_WIDTH-1:0]      lsu_rd;
  logic [DATA_WIDTH-1:0]      lsu_data;

  logic                       rf_wen;
  logic [ADDR_WIDTH-1:0]      rf_waddr;
  logic [DATA_WIDTH-1:0]      rf_wdata;
  logic [2**ADDR_WIDTH-1:0]   busy;

  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output issue_stall, alu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, busy
  );

  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  issue_stall, alu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin ALU/LSU arbitration into one registered
// register-file write per cycle, plus a per-register outstanding-write scoreboard.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);
  localparam int NREG = 2**ADDR_WIDTH;

  logic                  prio_q, prio_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic                  gnt_alu, gnt_lsu;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    // prio: 0 favours LSU, 1 favours ALU; after a conflict it names the loser
    gnt_alu = bus.alu_valid && (!bus.lsu_valid || prio_q);
    gnt_lsu = bus.lsu_valid && (!bus.alu_valid || !prio_q);
    prio_d  = prio_q;
    if (bus.alu_valid && bus.lsu_valid) prio_d = gnt_lsu;

    sel_rd   = gnt_alu ? bus.alu_rd   : bus.lsu_rd;
    sel_data = gnt_alu ? bus.alu_data : bus.lsu_data;

    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_alu || gnt_lsu) begin
      rf_wen_d   = (sel_rd != '0);
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end

    // Commit clears first so a same-edge issue to the same register wins
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      prio_q     <= prio_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.alu_ready   = gnt_alu;
  assign bus.lsu_ready   = gnt_lsu;
  assign bus.issue_stall = (bus.issue_rd != '0) && busy_q[bus.issue_rd];
  assign bus.rf_wen      = rf_wen_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single write, round-robin conflict,
// x0 handling, set-wins scoreboard, and asynchronous reset mid-write.
module tb_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic allow_reissue;

  wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_data    = '0;
  endtask

  // Decode must never issue into a stalled register (except the set-wins case)
  always @(negedge clk) begin
    if (rst_n && bus.issue_valid && !allow_reissue)
      chk("no_issue_on_stall", {63'd0, bus.issue_stall}, 64'd0);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    allow_reissue = 1'b0;
    rst_n = 1'b0;
    idle();

    // Reset with random non-valid inputs
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 31));
      bus.alu_rd      = 5'($urandom_range(0, 31));
      bus.alu_data    = $urandom;
      bus.lsu_rd      = 5'($urandom_range(0, 31));
      bus.lsu_data    = $urandom;
      cyc();
    end
    chk("rst_rf_wen",   64'(bus.rf_wen),   64'd0);
    chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    idle();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    // Single write: issue rd5, then ALU writes it back
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    #1;
    chk("sw_stall_pre", 64'(bus.issue_stall), 64'd0);
    cyc();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd5;
    bus.alu_data    = 32'hDEADBEEF;
    #1;
    chk("sw_alu_ready", 64'(bus.alu_ready),   64'd1);
    chk("sw_lsu_ready", 64'(bus.lsu_ready),   64'd0);
    chk("sw_stall_a",   64'(bus.issue_stall), 64'd1);
    chk("sw_busy_a",    64'(bus.busy),        64'h20);
    cyc();
    bus.alu_valid = 1'b0;
    #1;
    chk("sw_rf_wen",    64'(bus.rf_wen),      64'd1);
    chk("sw_rf_waddr",  64'(bus.rf_waddr),    64'd5);
    chk("sw_rf_wdata",  64'(bus.rf_wdata),    64'hDEADBEEF);
    chk("sw_stall_b",   64'(bus.issue_stall), 64'd1);
    chk("sw_busy_b",    64'(bus.busy),        64'h20);
    cyc();
    chk("sw_rf_wen_off", 64'(bus.rf_wen),      64'd0);
    chk("sw_busy_clr",   64'(bus.busy),        64'd0);
    chk("sw_stall_clr",  64'(bus.issue_stall), 64'd0);
    chk("sw_waddr_hold", 64'(bus.rf_waddr),    64'd5);
    bus.issue_rd = '0;

    // Conflict round-robin: LSU, ALU, LSU, ALU; winner rd = i+1
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1;
      bus.lsu_valid = 1'b1;
      bus.alu_rd    = 5'(i + 1);
      bus.lsu_rd    = 5'(i + 1);
      bus.alu_data  = 32'hA0 + 32'(i);
      bus.lsu_data  = 32'hB0 + 32'(i);
      #1;
      chk($sformatf("rr_lsu_ready%0d", i), 64'(bus.lsu_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("rr_alu_ready%0d", i), 64'(bus.alu_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i > 0) begin
        chk($sformatf("rr_waddr%0d", i - 1), 64'(bus.rf_waddr), 64'(i));
        chk($sformatf("rr_wdata%0d", i - 1), 64'(bus.rf_wdata),
            ((i - 1) % 2 == 0) ? 64'hB0 + 64'(i - 1) : 64'hA0 + 64'(i - 1));
      end
      cyc();
    end
    idle();
    #1;
    chk("rr_waddr3", 64'(bus.rf_waddr), 64'd4);
    chk("rr_wdata3", 64'(bus.rf_wdata), 64'hA3);
    chk("rr_wen3",   64'(bus.rf_wen),   64'd1);
    cyc();
    chk("rr_busy", 64'(bus.busy), 64'd0);

    // x0: issue rd3 first so "busy unchanged" is meaningful
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    cyc();
    bus.issue_rd  = 5'd0;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 32'h12345678;
    #1;
    chk("x0_lsu_ready", 64'(bus.lsu_ready),   64'd1);
    chk("x0_stall",     64'(bus.issue_stall), 64'd0);
    cyc();
    idle();
    #1;
    chk("x0_rf_wen",   64'(bus.rf_wen),   64'd0);
    chk("x0_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("x0_rf_wdata", 64'(bus.rf_wdata), 64'h12345678);
    chk("x0_busy",     64'(bus.busy),     64'h8);

    // Set-wins: re-issue rd7 in its own commit cycle
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    cyc();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd7;
    bus.alu_data    = 32'h77;
    cyc();
    bus.alu_valid   = 1'b0;
    allow_reissue   = 1'b1;
    bus.issue_valid = 1'b1;
    #1;
    chk("sw7_commit_wen", 64'(bus.rf_wen), 64'd1);
    cyc();
    bus.issue_valid = 1'b0;
    allow_reissue   = 1'b0;
    #1;
    chk("sw7_busy", 64'(bus.busy), 64'h88);
    chk("sw7_wen",  64'(bus.rf_wen), 64'd0);

    // Async reset mid-write; the conflict also moves prio to ALU
    bus.issue_rd  = '0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd9;
    bus.alu_data  = 32'h99;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd10;
    bus.lsu_data  = 32'hAA;
    #1;
    chk("ar_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    cyc();
    idle();
    #1;
    chk("ar_rf_wen_pre", 64'(bus.rf_wen),   64'd1);
    chk("ar_waddr_pre",  64'(bus.rf_waddr), 64'd10);
    rst_n = 1'b0;
    #1;
    chk("ar_rf_wen",   64'(bus.rf_wen),   64'd0);
    chk("ar_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("ar_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("ar_busy",     64'(bus.busy),     64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd2;
    #1;
    chk("ar_prio_lsu", 64'(bus.lsu_ready), 64'd1);
    chk("ar_prio_alu", 64'(bus.alu_ready), 64'd0);
    cyc();
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
